// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin owner of the 8-digit hex display with minimum dwell per view.
// Optional HEX_ARB_PREEMPT_EN: a rising req[0] preempts the current owner, ignoring the dwell.
module hex_display_arbiter #(
  parameter int NREQ         = 4,
  parameter int NDIG         = 8,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*4*NDIG-1:0]    data,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      valid,
  output logic [4*NDIG-1:0]         digits
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t          r_state, w_state_nx;
  logic [OW-1:0]   r_ptr, w_cand, w_sel;
  logic [CW-1:0]   r_cnt;
  logic            w_found, w_take, w_release, w_dec, w_preempt;
  logic [4*NDIG-1:0] w_view [NREQ];
  genvar i;
  for (i = 0; i < NREQ; i++) begin : g_view
    assign w_view[i] = data[i*4*NDIG +: 4*NDIG];
  end
  // Scan downward so the nearest requester after the pointer wins; the pointer itself comes last.
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (req[OW'((int'(r_ptr) + k) % NREQ)]) begin
        w_cand  = OW'((int'(r_ptr) + k) % NREQ);
        w_found = 1'b1;
      end
  end
`ifdef HEX_ARB_PREEMPT_EN
  logic r_req0;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_req0 <= 1'b0;
    else       r_req0 <= req[0];
  assign w_preempt = (r_state == HOLD) && req[0] && !r_req0 && (owner != '0);
`else
  assign w_preempt = 1'b0;
`endif
  always_comb begin
    w_take    = 1'b0;
    w_release = 1'b0;
    w_dec     = 1'b0;
    if (w_preempt) w_take = 1'b1;
    else if (r_state == IDLE) w_take = w_found;
    else if (!req[owner]) begin
      w_take    = w_found;
      w_release = !w_found;
    end
    else if (r_cnt != '0) w_dec = 1'b1;
    else w_take = w_found && (w_cand != owner);
    w_sel      = w_preempt ? '0 : w_cand;
    w_state_nx = w_take ? HOLD : w_release ? IDLE : r_state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      grant  <= '0;
      owner  <= '0;
      valid  <= 1'b0;
      digits <= '0;
      r_ptr  <= OW'(NREQ - 1);
      r_cnt  <= '0;
    end else begin
      if (w_take) begin
        grant <= NREQ'(1) << w_sel;
        owner <= w_sel;
        r_ptr <= w_sel;
        r_cnt <= CW'(DWELL_CYCLES - 1);
        valid <= 1'b1;
      end else if (w_release) begin
        grant <= '0;
        valid <= 1'b0;
      end else if (w_dec) r_cnt <= r_cnt - 1'b1;
      if (w_take) digits <= w_view[w_sel];
      else if (r_state == HOLD && !w_release) digits <= w_view[owner];
    end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: vector table plus scoreboard queue, with hand sequences for reset, live data and freeze.
module tb_hex_display_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req   = '0;
  logic [127:0] data;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         valid;
  logic [31:0]  digits;
  int total = 0;
  int bad   = 0;
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        valid;
    logic [1:0]  owner;
    logic [31:0] digits;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  hex_display_arbiter #(.NREQ(4), .NDIG(8), .DWELL_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data),
    .grant(grant), .owner(owner), .valid(valid), .digits(digits)
  );
  always #5 clock = ~clock;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o, input logic [31:0] d);
    vec_t v;
    v.req = r; v.grant = g; v.valid = (g != 4'b0); v.owner = o; v.digits = d;
    tbl.push_back(v);
  endtask
  task automatic now(input string tag, input logic [3:0] g, input logic v, input logic [1:0] o, input logic [31:0] d);
    cmp({tag, ".grant"}, 32'(grant), 32'(g));
    cmp({tag, ".valid"}, 32'(valid), 32'(v));
    cmp({tag, ".owner"}, 32'(owner), 32'(o));
    cmp({tag, ".digits"}, digits, d);
  endtask
  task automatic check_sb(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      now(tag, e.grant, e.valid, e.owner, e.digits);
      cmp({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
    end
  endtask
  task automatic step(input string tag, input vec_t v);
    req = v.req;
    sb.push_back(v);
    @(posedge clock);
    #1;
    check_sb(tag);
  endtask
  task automatic hstep(input string tag, input logic [3:0] r, input logic [3:0] g, input logic [1:0] o, input logic [31:0] d);
    vec_t v;
    v.req = r; v.grant = g; v.valid = (g != 4'b0); v.owner = o; v.digits = d;
    step(tag, v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end
  initial begin
    data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    for (int c = 0; c < 10; c++) add(4'b0000, 4'b0000, 2'd0, 32'h0);
    add(4'b0110, 4'b0010, 2'd1, 32'h11111111);
    add(4'b0000, 4'b0000, 2'd1, 32'h11111111);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        add(4'b0011, (r % 2 == 1) ? 4'b0010 : 4'b0001, 2'(r % 2), (r % 2 == 1) ? 32'h11111111 : 32'h0);
    add(4'b0000, 4'b0000, 2'd0, 32'h0);
    add(4'b0100, 4'b0100, 2'd2, 32'h22222222);
`ifdef HEX_ARB_PREEMPT_EN
    for (int c = 0; c < 4; c++) add(4'b0101, 4'b0001, 2'd0, 32'h0);
    add(4'b0101, 4'b0100, 2'd2, 32'h22222222);
    add(4'b0000, 4'b0000, 2'd2, 32'h22222222);
`else
    for (int c = 0; c < 3; c++) add(4'b0101, 4'b0100, 2'd2, 32'h22222222);
    for (int c = 0; c < 2; c++) add(4'b0101, 4'b0001, 2'd0, 32'h0);
    add(4'b0000, 4'b0000, 2'd0, 32'h0);
`endif
    for (int c = 0; c < 6; c++) add(4'b1000, 4'b1000, 2'd3, 32'h33333333);
    add(4'b0000, 4'b0000, 2'd3, 32'h33333333);
    #1;
    now("in_reset", 4'b0000, 1'b0, 2'd0, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    now("after_reset", 4'b0000, 1'b0, 2'd0, 32'h0);
    foreach (tbl[n]) step($sformatf("vec%0d", n), tbl[n]);
    hstep("hold1", 4'b0010, 4'b0010, 2'd1, 32'h11111111);
    @(negedge clock);
    req = 4'b0000;
    reset = 1'b1;
    #1;
    now("async_reset", 4'b0000, 1'b0, 2'd0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    hstep("post_reset", 4'b1000, 4'b1000, 2'd3, 32'h33333333);
    data[127:96] = 32'hDEADBEEF;
    hstep("live_data", 4'b1000, 4'b1000, 2'd3, 32'hDEADBEEF);
    hstep("release", 4'b0000, 4'b0000, 2'd3, 32'hDEADBEEF);
    data[127:96] = 32'h33333333;
    hstep("idle_freeze", 4'b0000, 4'b0000, 2'd3, 32'hDEADBEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
